bfm_unit: RTL and testbench

- Registered two-operand adder model sitting behind the stimulus wrapper.
- Every clock it samples operands A_s and B_s and returns their modular sum on res_o after a fixed pipeline latency.
- It also provides a carry-out flag, an output-valid flag and a free-running count of sums produced, for scoreboard use.
- There is no input handshake: the operands are treated as valid on every cycle out of reset.

---
 rtl/bfm_pkg.sv | 14 +
 rtl/bfm_pipe_reg.sv | 19 +
 rtl/bfm_unit.sv | 69 ++++++
 tb/tb_bfm_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/bfm_pkg.sv
// Shared defaults and the pipeline stage record for the scoreboard adder model.
package bfm_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 32;

  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] sum;
  } pipe_stage_t;

endpackage

// File: rtl/bfm_pipe_reg.sv
// One synchronous-reset pipeline stage; the record type is a parameter so the
// top can pass a stage record sized to its own WIDTH.
module bfm_pipe_reg
  import bfm_pkg::*;
#(
  parameter type T = pipe_stage_t
) (
  input  logic clk_i,
  input  logic reset_i,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk_i) begin
    if (!reset_i) q <= '0;
    else          q <= d;
  end

endmodule

// File: rtl/bfm_unit.sv
// Registered two-operand adder with configurable latency, carry and valid
// flags, and a running count of sums produced since reset.
module bfm_unit
  import bfm_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] A_s,
  input  logic [WIDTH-1:0] B_s,
  output logic [WIDTH-1:0] res_o,
  output logic             carry_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
  } stage_t;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("bfm_unit: LATENCY must be in the range 1..4");
  end

  logic [WIDTH:0]   full_sum;
  stage_t           first;
  stage_t           stage_d [LATENCY];
  stage_t           stage_q [LATENCY];
  logic [CNT_W-1:0] count;

  always_comb begin
    full_sum    = {1'b0, A_s} + {1'b0, B_s};
    first.valid = 1'b1;
    first.carry = full_sum[WIDTH];
    first.sum   = full_sum[WIDTH-1:0];
  end

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign stage_d[i] = first;
    end else begin : g_tail
      assign stage_d[i] = stage_q[i-1];
    end

    bfm_pipe_reg #(.T(stage_t)) u_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .d       (stage_d[i]),
      .q       (stage_q[i])
    );
  end

  // Counting on the valid entering the last stage keeps count_o in step with valid_o.
  always_ff @(posedge clk_i) begin
    if (!reset_i)                      count <= '0;
    else if (stage_d[LATENCY-1].valid) count <= count + CNT_W'(1);
  end

  assign res_o   = stage_q[LATENCY-1].sum;
  assign carry_o = stage_q[LATENCY-1].carry;
  assign valid_o = stage_q[LATENCY-1].valid;
  assign count_o = count;

endmodule

// File: tb/tb_bfm_unit.sv
// Self-checking bench: a LATENCY=1 and a LATENCY=3 instance share stimulus and
// are compared against a queue-based reference model plus fixed vectors.
module tb_bfm_unit;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  a_s;
  logic [7:0]  b_s;

  logic [7:0]  res1, res3;
  logic        carry1, carry3;
  logic        valid1, valid3;
  logic [31:0] count1, count3;

  typedef struct packed {
    logic       valid;
    logic       carry;
    logic [7:0] sum;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       carry;
  } vec_t;

  exp_t        q1[$];
  exp_t        q3[$];
  exp_t        exp1, exp3;
  logic [31:0] cnt1, cnt3;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  bfm_unit #(.WIDTH(8), .LATENCY(1), .CNT_W(32)) dut1 (
    .clk_i(clk), .reset_i(reset_i), .A_s(a_s), .B_s(b_s),
    .res_o(res1), .carry_o(carry1), .valid_o(valid1), .count_o(count1)
  );

  bfm_unit #(.WIDTH(8), .LATENCY(3), .CNT_W(32)) dut3 (
    .clk_i(clk), .reset_i(reset_i), .A_s(a_s), .B_s(b_s),
    .res_o(res3), .carry_o(carry3), .valid_o(valid3), .count_o(count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference model: results queue up behind the sampling edge and a reset
  // flushes everything that was in flight.
  task automatic modelStep(input logic rst_n, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] full;
    exp_t       e;
    full    = {1'b0, a} + {1'b0, b};
    e.valid = 1'b1;
    e.carry = full[8];
    e.sum   = full[7:0];
    if (!rst_n) begin
      q1.delete();
      q3.delete();
      for (int i = 0; i < 2; i++) q3.push_back('0);
      exp1 = '0;
      exp3 = '0;
      cnt1 = 0;
      cnt3 = 0;
    end else begin
      q1.push_back(e);
      q3.push_back(e);
      exp1 = q1.pop_front();
      exp3 = q3.pop_front();
      cnt1 = cnt1 + 32'(exp1.valid);
      cnt3 = cnt3 + 32'(exp3.valid);
    end
  endtask

  task automatic checkOutput();
    check("res1",   32'(res1),   32'(exp1.sum));
    check("carry1", 32'(carry1), 32'(exp1.carry));
    check("valid1", 32'(valid1), 32'(exp1.valid));
    check("count1", count1,      cnt1);
    check("res3",   32'(res3),   32'(exp3.sum));
    check("carry3", 32'(carry3), 32'(exp3.carry));
    check("valid3", 32'(valid3), 32'(exp3.valid));
    check("count3", count3,      cnt3);
  endtask

  task automatic applyStimulus(input logic rst_n, input logic [7:0] a, input logic [7:0] b);
    reset_i = rst_n;
    a_s     = a;
    b_s     = b;
    @(posedge clk);
    #1;
    modelStep(rst_n, a, b);
    checkOutput();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 8'hFF, 1'b0};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 8'h46, 1'b0};
    vecs[5] = '{8'h7F, 8'h01, 8'h80, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 8'h2C, 1'b1};

    reset_i = 1'b0;
    a_s     = 8'h12;
    b_s     = 8'h34;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h12, 8'h34);
      check("rst_res1",   32'(res1),   32'h0);
      check("rst_valid1", 32'(valid1), 32'h0);
      check("rst_count1", count1,      32'h0);
      check("rst_valid3", 32'(valid3), 32'h0);
    end

    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h12, 8'h34);
      check("rel_res1",   32'(res1),   32'h46);
      check("rel_carry1", 32'(carry1), 32'h0);
      check("rel_valid1", 32'(valid1), 32'h1);
      check("rel_count1", count1,      32'(i + 1));
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, vecs[i].a, vecs[i].b);
      check("vec_res1",   32'(res1),   32'(vecs[i].sum));
      check("vec_carry1", 32'(carry1), 32'(vecs[i].carry));
      check("vec_valid1", 32'(valid1), 32'h1);
    end

    // Three-stage instance: operands sampled on the release edge emerge two edges later.
    applyStimulus(1'b0, 8'h05, 8'h0A);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1, 8'h05, 8'h0A);
      check("lat3_valid", 32'(valid3), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) begin
        check("lat3_res",   32'(res3), 32'h0F);
        check("lat3_count", count3,    32'h1);
      end
    end

    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'($urandom), 8'($urandom));
    applyStimulus(1'b0, 8'h33, 8'h44);
    check("midrst_res1",   32'(res1),   32'h0);
    check("midrst_carry1", 32'(carry1), 32'h0);
    check("midrst_valid1", 32'(valid1), 32'h0);
    check("midrst_count1", count1,      32'h0);
    check("midrst_valid3", 32'(valid3), 32'h0);
    check("midrst_count3", count3,      32'h0);
    applyStimulus(1'b1, 8'h33, 8'h44);
    check("restart_count1", count1,    32'h1);
    check("restart_res1",   32'(res1), 32'h77);

    for (int i = 0; i < 1000; i++) applyStimulus(1'b1, 8'($urandom), 8'($urandom));
    check("final_count1", count1, 32'd1001);
    check("final_count3", count3, 32'd999);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
